// File: rtl/iob_rr_merge_pkg.sv
// Shared IOb native interconnect definitions: bus widths, field positions and FSM states.
// Reused by the merge and split blocks.
package iob_rr_merge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Request slot layout, MSB first: {valid, addr, wdata, wstrb}
    function automatic int unsigned req_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    // Response slot layout, MSB first: {rdata, ready}
    function automatic int unsigned resp_w(input int unsigned data_w);
        return data_w + 1;
    endfunction

    function automatic int unsigned req_valid_pos(input int unsigned addr_w, input int unsigned data_w);
        return req_w(addr_w, data_w) - 1;
    endfunction

    function automatic int unsigned resp_ready_pos();
        return 0;
    endfunction

    // Index width for N requesters, never narrower than one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_pick.sv
// Rotated priority encoder: lowest-index valid at or above ptr, wrapping to the bottom.
module iob_rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned NB = 1
) (
    input  logic [N-1:0]  valid,
    input  logic [NB-1:0] ptr,
    output logic [NB-1:0] pick,
    output logic          any_valid
);

    logic [NB-1:0] pick_hi;
    logic [NB-1:0] pick_lo;
    logic          found_hi;

    // Descending scan so the last hit in each half is the lowest index of that half
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid[i]) begin
                if (i >= 32'(ptr)) begin
                    pick_hi  = NB'(i);
                    found_hi = 1'b1;
                end else begin
                    pick_lo = NB'(i);
                end
            end
        end
        pick      = found_hi ? pick_hi : pick_lo;
        any_valid = |valid;
    end

endmodule

// File: rtl/iob_rr_merge.sv
// N-master to 1-slave round-robin merge for the IOb native interconnect.
// Optional slave response timeout enabled by defining IOB_RR_MERGE_TIMEOUT_EN.
module iob_rr_merge
    import iob_rr_merge_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [N_MASTERS*req_w(ADDR_W, DATA_W)-1:0]    m_req,
    output logic [N_MASTERS*resp_w(DATA_W)-1:0]           m_resp,
    output logic [req_w(ADDR_W, DATA_W)-1:0]              s_req,
    input  logic [resp_w(DATA_W)-1:0]                     s_resp
);

    localparam int unsigned REQ_W     = req_w(ADDR_W, DATA_W);
    localparam int unsigned RESP_W    = resp_w(DATA_W);
    localparam int unsigned NB        = idx_w(N_MASTERS);
    localparam int unsigned VALID_POS = req_valid_pos(ADDR_W, DATA_W);
    localparam int unsigned READY_POS = resp_ready_pos();

    if (N_MASTERS < 1 || TIMEOUT < 2) begin : g_bad_cfg
        $error("iob_rr_merge: N_MASTERS must be >= 1 and TIMEOUT >= 2");
    end

    state_t            state;
    logic [NB-1:0]     grant;
    logic [NB-1:0]     ptr;
    logic [NB-1:0]     pick;
    logic [NB-1:0]     ptr_nxt;
    logic              any_valid;
    logic [N_MASTERS-1:0] valid;
    logic              s_ready;
    logic              tout;
    logic              done;

    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            valid[i] = m_req[i*REQ_W + VALID_POS];
        end
    end

    iob_rr_pick #(
        .N  (N_MASTERS),
        .NB (NB)
    ) u_pick (
        .valid     (valid),
        .ptr       (ptr),
        .pick      (pick),
        .any_valid (any_valid)
    );

    assign s_ready = s_resp[READY_POS];
    assign ptr_nxt = NB'((32'(grant) + 32'd1) % N_MASTERS);

`ifdef IOB_RR_MERGE_TIMEOUT_EN
    localparam int unsigned TCNT_W = idx_w(TIMEOUT);

    logic [TCNT_W-1:0] tcnt;

    assign tout = (state == BUSY) && !s_ready && (tcnt == TCNT_W'(TIMEOUT - 1));

    // Counts BUSY cycles without ready; held at zero while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (state == IDLE) begin
            tcnt <= '0;
        end else if (!s_ready && !tout) begin
            tcnt <= tcnt + 1'b1;
        end
    end
`else
    assign tout = 1'b0;
`endif

    assign done = (state == BUSY) && (s_ready || tout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant <= pick;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        ptr   <= ptr_nxt;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-latency forward and response routing; reset blanks both directions
    always_comb begin
        s_req  = '0;
        m_resp = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        s_req = m_req[32'(pick)*REQ_W +: REQ_W];
                    end
                end
                BUSY: begin
                    s_req = m_req[32'(grant)*REQ_W +: REQ_W];
                    if (s_ready) begin
                        m_resp[32'(grant)*RESP_W +: RESP_W] = s_resp;
                    end else if (tout) begin
                        s_req = '0;
                        m_resp[32'(grant)*RESP_W +: RESP_W] = {{DATA_W{1'b1}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_rr_merge.sv
// Directed self-checking bench for iob_rr_merge (N_MASTERS=2, 32-bit bus, TIMEOUT=8).
// Timeout scenario runs only when IOB_RR_MERGE_TIMEOUT_EN is defined.
module tb_iob_rr_merge;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned N      = 2;
    localparam int unsigned REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int unsigned RESP_W = DATA_W + 1;

    logic                clk;
    logic                rst;
    logic [N*REQ_W-1:0]  m_req;
    logic [N*RESP_W-1:0] m_resp;
    logic [REQ_W-1:0]    s_req;
    logic [RESP_W-1:0]   s_resp;

    int checks;
    int errors;

    iob_rr_merge #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .N_MASTERS (N),
        .TIMEOUT   (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req),
        .m_resp (m_resp),
        .s_req  (s_req),
        .s_resp (s_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] mk_req(input logic [31:0] addr, input logic [31:0] wdata,
                                                input logic [3:0] wstrb);
        return {1'b1, addr, wdata, wstrb};
    endfunction

    function automatic logic [RESP_W-1:0] mk_resp(input logic [31:0] rdata);
        return {rdata, 1'b1};
    endfunction

    function automatic logic [N*RESP_W-1:0] slot(input int idx, input logic [RESP_W-1:0] r);
        logic [N*RESP_W-1:0] v;
        v = '0;
        if (idx == 0) v[RESP_W-1:0] = r;
        else          v[2*RESP_W-1:RESP_W] = r;
        return v;
    endfunction

    function automatic logic [REQ_W-1:0] rr_payload(input int idx, input int cnt);
        return mk_req(32'h100 + 32'(idx * 16 + cnt), 32'hD000_0000 + 32'(idx * 256 + cnt), 4'hF);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [REQ_W-1:0]  r0;
    logic [REQ_W-1:0]  r1;
    logic [RESP_W-1:0] rs;
    int                cnt [2];

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        m_req  = '0;
        s_resp = '0;

        // Reset state, including a valid presented while reset is held
        next_cycle();
        @(negedge clk);
        check("rst_sreq", 128'(s_req), 128'(0));
        check("rst_mresp", 128'(m_resp), 128'(0));
        r0 = mk_req(32'h10, 32'hCAFE0001, 4'hF);
        m_req = {{REQ_W{1'b0}}, r0};
        @(negedge clk);
        check("rst_gate_sreq", 128'(s_req), 128'(0));
        next_cycle();
        m_req = '0;
        rst   = 1'b0;
        next_cycle();

        // Contention from ptr=0: four back-to-back requests per master alternate 0,1,0,1...
        cnt[0] = 0;
        cnt[1] = 0;
        m_req = {rr_payload(1, 0), rr_payload(0, 0)};
        for (int k = 0; k < 8; k++) begin
            s_resp = '0;
            @(negedge clk);
            check("rr_fwd", 128'(s_req), 128'(rr_payload(k % 2, cnt[k % 2])));
            check("rr_wait", 128'(m_resp), 128'(0));
            next_cycle();
            rs = mk_resp(32'hB000_0000 + 32'(k));
            s_resp = rs;
            @(negedge clk);
            check("rr_resp", 128'(m_resp), 128'(slot(k % 2, rs)));
            next_cycle();
            cnt[k % 2]++;
            if (k % 2 == 0)
                m_req[REQ_W-1:0] = (cnt[0] < 4) ? rr_payload(0, cnt[0]) : '0;
            else
                m_req[2*REQ_W-1:REQ_W] = (cnt[1] < 4) ? rr_payload(1, cnt[1]) : '0;
        end
        s_resp = '0;
        @(negedge clk);
        check("rr_drained", 128'(s_req), 128'(0));
        next_cycle();

        // Single master, slave ready two cycles after valid
        r0 = mk_req(32'h10, 32'hCAFE0001, 4'hF);
        m_req = {{REQ_W{1'b0}}, r0};
        @(negedge clk);
        check("single_fwd_c0", 128'(s_req), 128'(r0));
        next_cycle();
        @(negedge clk);
        check("single_fwd_c1", 128'(s_req), 128'(r0));
        check("single_wait_c1", 128'(m_resp), 128'(0));
        next_cycle();
        rs = mk_resp(32'hAAAA5555);
        s_resp = rs;
        @(negedge clk);
        check("single_resp_c2", 128'(m_resp), 128'(slot(0, rs)));
        next_cycle();
        m_req  = '0;
        s_resp = '0;
        @(negedge clk);
        check("single_idle", 128'(s_req), 128'(0));
        next_cycle();

        // Response isolation: m1 alone gets rdata, m0 slot stays zero
        r1 = mk_req(32'h2000, 32'h0BAD_F00D, 4'h3);
        m_req = {r1, {REQ_W{1'b0}}};
        @(negedge clk);
        check("iso_fwd", 128'(s_req), 128'(r1));
        next_cycle();
        rs = mk_resp(32'h12345678);
        s_resp = rs;
        @(negedge clk);
        check("iso_resp", 128'(m_resp), 128'(slot(1, rs)));
        next_cycle();
        m_req  = '0;
        s_resp = '0;
        next_cycle();

        // Stray ready in IDLE: nothing routed, ptr still 0 so m0 wins next contention
        s_resp = mk_resp(32'h5A5A5A5A);
        @(negedge clk);
        check("stray_mresp", 128'(m_resp), 128'(0));
        check("stray_sreq", 128'(s_req), 128'(0));
        next_cycle();
        s_resp = '0;
        r0 = mk_req(32'h30, 32'h00000030, 4'hF);
        r1 = mk_req(32'h31, 32'h00000031, 4'hF);
        m_req = {r1, r0};
        @(negedge clk);
        check("stray_ptr_keep", 128'(s_req), 128'(r0));
        next_cycle();
        rs = mk_resp(32'h0000_0030);
        s_resp = rs;
        @(negedge clk);
        check("stray_resp", 128'(m_resp), 128'(slot(0, rs)));
        next_cycle();
        m_req  = '0;
        s_resp = '0;
        next_cycle();

        // Reset while BUSY (ptr=1 beforehand), then a late ready
        r0 = mk_req(32'h40, 32'h00000040, 4'hF);
        m_req = {{REQ_W{1'b0}}, r0};
        next_cycle();
        @(negedge clk);
        check("mid_busy", 128'(s_req), 128'(r0));
        next_cycle();
        rst   = 1'b1;
        m_req = '0;
        @(negedge clk);
        check("mid_rst_sreq", 128'(s_req), 128'(0));
        check("mid_rst_mresp", 128'(m_resp), 128'(0));
        next_cycle();
        rst = 1'b0;
        s_resp = mk_resp(32'hDEAD_BEEF);
        @(negedge clk);
        check("late_ready", 128'(m_resp), 128'(0));
        next_cycle();
        s_resp = '0;
        r0 = mk_req(32'h50, 32'h00000050, 4'hF);
        r1 = mk_req(32'h51, 32'h00000051, 4'hF);
        m_req = {r1, r0};
        @(negedge clk);
        check("post_rst_ptr0", 128'(s_req), 128'(r0));
        next_cycle();
        rs = mk_resp(32'h0000_0050);
        s_resp = rs;
        @(negedge clk);
        check("post_rst_r0", 128'(m_resp), 128'(slot(0, rs)));
        next_cycle();
        s_resp = '0;
        m_req  = {r1, {REQ_W{1'b0}}};
        @(negedge clk);
        check("post_rst_m1", 128'(s_req), 128'(r1));
        next_cycle();
        rs = mk_resp(32'h0000_0051);
        s_resp = rs;
        @(negedge clk);
        check("post_rst_r1", 128'(m_resp), 128'(slot(1, rs)));
        next_cycle();
        m_req  = '0;
        s_resp = '0;
        next_cycle();

`ifdef IOB_RR_MERGE_TIMEOUT_EN
        // Slave never readies: m0 gets all-ones error in BUSY cycle 8, then m1 is granted
        r0 = mk_req(32'h60, 32'h00000060, 4'hF);
        r1 = mk_req(32'h61, 32'h00000061, 4'hF);
        m_req = {r1, r0};
        @(negedge clk);
        check("to_fwd", 128'(s_req), 128'(r0));
        next_cycle();
        for (int b = 1; b < 8; b++) begin
            @(negedge clk);
            check("to_wait", 128'(m_resp), 128'(0));
            next_cycle();
        end
        @(negedge clk);
        check("to_resp", 128'(m_resp), 128'(slot(0, {32'hFFFF_FFFF, 1'b1})));
        check("to_sreq", 128'(s_req), 128'(0));
        next_cycle();
        m_req = {r1, {REQ_W{1'b0}}};
        @(negedge clk);
        check("to_next", 128'(s_req), 128'(r1));
        next_cycle();
        rs = mk_resp(32'h0000_0061);
        s_resp = rs;
        @(negedge clk);
        check("to_next_resp", 128'(m_resp), 128'(slot(1, rs)));
        next_cycle();
        m_req  = '0;
        s_resp = '0;
        next_cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
